mult_share_ctrl: RTL and testbench

Round-robin controller that shares one clock-gated 16x16 exact multiplier among NREQ requesters. It accepts one operand pair at a time through per-requester valid/ready handshakes and drives the multiplier's gating enable for exactly one cycle per operation. It captures the product from the multiplier's negedge-registered output and returns it with the requester ID through a valid/ready response port. It sits between the compute clients and the gated multiplier, and its purpose is to keep the multiplier clock idle whenever there is no work.

---
 rtl/mult_share_ctrl_pkg.sv | 25 ++
 rtl/mult_share_ctrl_if.sv | 40 ++++
 rtl/mult_share_ctrl_arb.sv | 37 +++
 rtl/mult_share_ctrl.sv | 127 ++++++++++++
 tb/tb_mult_share_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_ctrl_pkg
// Brief    : Shared types and constants for the multiplier-sharing controller.
// Revision : 1.0 - initial release
// ============================================================================
package mult_share_ctrl_pkg;

    localparam int MUL_W  = 16;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    // Index width that stays legal (>=1) even for a single entry.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_share_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_ctrl_if
// Brief    : Request, response and multiplier-side signals of the controller.
// Revision : 1.0 - initial release
// ============================================================================
interface mult_share_ctrl_if
    import mult_share_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) ();

    localparam int IDW = idx_width(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [MUL_W*NREQ-1:0] req_a;
    logic [MUL_W*NREQ-1:0] req_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [PROD_W-1:0]     resp_y;
    logic                  mul_en;
    logic [MUL_W-1:0]      mul_a;
    logic [MUL_W-1:0]      mul_b;
    logic [PROD_W-1:0]     mul_y;
    logic                  busy;

    modport slave (
        input  req_valid, req_a, req_b, resp_ready, mul_y,
        output req_ready, resp_valid, resp_id, resp_y, mul_en, mul_a, mul_b, busy
    );

    modport master (
        output req_valid, req_a, req_b, resp_ready, mul_y,
        input  req_ready, resp_valid, resp_id, resp_y, mul_en, mul_a, mul_b, busy
    );

endinterface
`default_nettype wire

// File: rtl/mult_share_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_onehot
// Brief    : Combinational round-robin pick, searching upward from ptr+1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_onehot
    import mult_share_ctrl_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = idx_width(NREQ)
) (
    input  wire logic [NREQ-1:0] i_req_valid,
    input  wire logic [IDW-1:0]  i_ptr,
    output logic      [NREQ-1:0] o_grant,
    output logic      [IDW-1:0]  o_idx,
    output logic                 o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Outer loop walks priority order; inner loop keeps every bit index constant.
        for (int off = 1; off <= NREQ; off++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!o_any && i_req_valid[i] && (((int'(i_ptr) + off) % NREQ) == i)) begin
                    o_any      = 1'b1;
                    o_grant[i] = 1'b1;
                    o_idx      = IDW'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mult_share_ctrl
// Brief    : Round-robin sharing of one clock-gated 16x16 multiplier.
//            Optional MULT_SHARE_CTRL_ZERO_BYPASS_EN skips the multiplier for
//            zero operands.
// Revision : 1.0 - initial release
// ============================================================================
module mult_share_ctrl
    import mult_share_ctrl_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 1
) (
    input wire logic        clk,
    input wire logic        rst,
    mult_share_ctrl_if.slave bus
);

    localparam int IDW = idx_width(NREQ);
    localparam int CW  = idx_width(MUL_LAT) + 1;

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_ISSUE = ISSUE;
    localparam logic [1:0] ST_WAIT  = WAIT;
    localparam logic [1:0] ST_RESP  = RESP;

    logic [1:0]        r_state;
    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_resp_id;
    logic [PROD_W-1:0] r_resp_y;
    logic [MUL_W-1:0]  r_mul_a;
    logic [MUL_W-1:0]  r_mul_b;
    logic              r_mul_en;
    logic [CW-1:0]     r_cnt;

    logic [NREQ-1:0]   w_grant;
    logic [IDW-1:0]    w_idx;
    logic              w_any;
    logic [MUL_W-1:0]  w_gnt_a;
    logic [MUL_W-1:0]  w_gnt_b;
    logic              w_zero;

    rr_arbiter_onehot #(.NREQ(NREQ)) u_arb (
        .i_req_valid (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    assign w_gnt_a = bus.req_a[int'(w_idx)*MUL_W +: MUL_W];
    assign w_gnt_b = bus.req_b[int'(w_idx)*MUL_W +: MUL_W];

`ifdef MULT_SHARE_CTRL_ZERO_BYPASS_EN
    assign w_zero = (w_gnt_a == '0) || (w_gnt_b == '0);
`else
    assign w_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= IDW'(NREQ - 1);
            r_resp_id <= '0;
            r_resp_y  <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_mul_en  <= 1'b0;
            r_cnt     <= '0;
        end else begin
            // Registered enable keeps the gating signal glitch-free and one cycle wide.
            r_mul_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_ptr     <= w_idx;
                        r_resp_id <= w_idx;
                        if (w_zero) begin
                            r_resp_y <= '0;
                            r_state  <= ST_RESP;
                        end else begin
                            r_mul_a  <= w_gnt_a;
                            r_mul_b  <= w_gnt_b;
                            r_mul_en <= 1'b1;
                            r_state  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (MUL_LAT == 1) begin
                        r_resp_y <= bus.mul_y;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt   <= CW'(MUL_LAT - 2);
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_resp_y <= bus.mul_y;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE) ? w_grant : '0;
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_y     = r_resp_y;
    assign bus.mul_en     = r_mul_en;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mult_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_share_ctrl
// Brief    : Self-checking bench for mult_share_ctrl with a negedge multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_share_ctrl;
    import mult_share_ctrl_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

`ifdef MULT_SHARE_CTRL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mult_share_ctrl_if #(.NREQ(NREQ)) bus ();

    mult_share_ctrl #(.NREQ(NREQ), .MUL_LAT(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Gated multiplier: only clocks (on negedge) when enabled.
    always @(negedge clk) if (bus.mul_en) bus.mul_y <= 32'(bus.mul_a) * 32'(bus.mul_b);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    y;
    } exp_t;

    exp_t        sb[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] last_a  = '0;
    logic [15:0] last_b  = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.req_valid = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_a = '0;
        last_b = '0;
        sb.delete();
    endtask

    task automatic test_reset();
        apply_reset();
        n_total++; if (bus.req_ready !== 4'b0)   $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); else n_pass++;
        n_total++; if (bus.resp_valid !== 1'b0)  $display("FAIL reset_resp_valid got=%b want=0", bus.resp_valid); else n_pass++;
        n_total++; if (bus.resp_id !== 2'd0)     $display("FAIL reset_resp_id got=%0d want=0", bus.resp_id); else n_pass++;
        n_total++; if (bus.resp_y !== 32'd0)     $display("FAIL reset_resp_y got=%h want=0", bus.resp_y); else n_pass++;
        n_total++; if (bus.mul_en !== 1'b0)      $display("FAIL reset_mul_en got=%b want=0", bus.mul_en); else n_pass++;
        n_total++; if (bus.mul_a !== 16'd0)      $display("FAIL reset_mul_a got=%h want=0", bus.mul_a); else n_pass++;
        n_total++; if (bus.mul_b !== 16'd0)      $display("FAIL reset_mul_b got=%h want=0", bus.mul_b); else n_pass++;
        n_total++; if (bus.busy !== 1'b0)        $display("FAIL reset_busy got=%b want=0", bus.busy); else n_pass++;
    endtask

    task automatic test_op(input int id, input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] want, input string nm);
        exp_t e;
        bit   byp;
        bus.resp_ready = 1'b1;
        bus.req_a[id*16 +: 16] = a;
        bus.req_b[id*16 +: 16] = b;
        bus.req_valid = NREQ'(1) << id;
        #1;
        n_total++; if (bus.req_ready !== (NREQ'(1) << id)) $display("FAIL %s_req_ready got=%b want=%b", nm, bus.req_ready, NREQ'(1) << id); else n_pass++;
        sb.push_back('{id: IDW'(id), y: 32'(a) * 32'(b)});
        tick();
        bus.req_valid = '0;
        byp = BYPASS && ((a == 16'd0) || (b == 16'd0));
        if (!byp) begin
            n_total++; if (bus.mul_en !== 1'b1)     $display("FAIL %s_mul_en_on got=%b want=1", nm, bus.mul_en); else n_pass++;
            n_total++; if (bus.mul_a !== a)         $display("FAIL %s_mul_a got=%h want=%h", nm, bus.mul_a, a); else n_pass++;
            n_total++; if (bus.mul_b !== b)         $display("FAIL %s_mul_b got=%h want=%h", nm, bus.mul_b, b); else n_pass++;
            n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL %s_early_resp got=%b want=0", nm, bus.resp_valid); else n_pass++;
            tick();
            n_total++; if (bus.mul_en !== 1'b0)     $display("FAIL %s_mul_en_off got=%b want=0", nm, bus.mul_en); else n_pass++;
            last_a = a;
            last_b = b;
        end else begin
            n_total++; if (bus.mul_en !== 1'b0)     $display("FAIL %s_byp_mul_en got=%b want=0", nm, bus.mul_en); else n_pass++;
            n_total++; if (bus.mul_a !== last_a)    $display("FAIL %s_byp_mul_a got=%h want=%h", nm, bus.mul_a, last_a); else n_pass++;
        end
        e = sb.pop_front();
        n_total++; if (bus.resp_valid !== 1'b1) $display("FAIL %s_resp_valid got=%b want=1", nm, bus.resp_valid); else n_pass++;
        n_total++; if (bus.resp_y !== e.y)      $display("FAIL %s_resp_y got=%h want=%h", nm, bus.resp_y, e.y); else n_pass++;
        n_total++; if (bus.resp_y !== want)     $display("FAIL %s_resp_y_const got=%h want=%h", nm, bus.resp_y, want); else n_pass++;
        n_total++; if (bus.resp_id !== e.id)    $display("FAIL %s_resp_id got=%0d want=%0d", nm, bus.resp_id, e.id); else n_pass++;
        tick();
        n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL %s_resp_drop got=%b want=0", nm, bus.resp_valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b0)       $display("FAIL %s_idle_busy got=%b want=0", nm, bus.busy); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [15:0] av[NREQ];
        logic [15:0] bv[NREQ];
        int   order[$] = '{0, 1, 2, 3, 0};
        int   grants = 0;
        int   g, w;
        bit   prev_en = 1'b0;
        exp_t e;
        apply_reset();
        for (int i = 0; i < NREQ; i++) begin
            av[i] = 16'(1000 + 4321 * i);
            bv[i] = 16'(7 + 9000 * i);
            bus.req_a[i*16 +: 16] = av[i];
            bus.req_b[i*16 +: 16] = bv[i];
        end
        bus.resp_ready = 1'b1;
        bus.req_valid  = '1;
        #1;
        for (int cyc = 0; cyc < 80 && !(grants == 5 && sb.size() == 0); cyc++) begin
            if (bus.resp_valid) begin
                if (sb.size() == 0) begin
                    n_total++; $display("FAIL rr_spurious_resp got id=%0d want=none", bus.resp_id);
                end else begin
                    e = sb.pop_front();
                    n_total++; if (bus.resp_id !== e.id) $display("FAIL rr_resp_id got=%0d want=%0d", bus.resp_id, e.id); else n_pass++;
                    n_total++; if (bus.resp_y !== e.y)   $display("FAIL rr_resp_y got=%h want=%h", bus.resp_y, e.y); else n_pass++;
                end
            end
            if (|(bus.req_valid & bus.req_ready)) begin
                g = -1;
                for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
                w = order.pop_front();
                n_total++; if (!$onehot(bus.req_ready) || g != w) $display("FAIL rr_grant got=%b want_idx=%0d", bus.req_ready, w); else n_pass++;
                sb.push_back('{id: IDW'(w), y: 32'(av[w]) * 32'(bv[w])});
                grants++;
            end
            if (bus.mul_en) begin
                n_total++; if (prev_en) $display("FAIL rr_mul_en_width got=2+ cycles want=1"); else n_pass++;
            end
            prev_en = bus.mul_en;
            tick();
            if (grants == 5) bus.req_valid = '0;
        end
        n_total++; if (grants != 5 || sb.size() != 0) $display("FAIL rr_complete got grants=%0d pending=%0d want 5/0", grants, sb.size()); else n_pass++;
    endtask

    task automatic test_backpressure();
        exp_t e;
        apply_reset();
        bus.req_a[16 +: 16] = 16'h1234;
        bus.req_b[16 +: 16] = 16'h00FF;
        bus.req_a[32 +: 16] = 16'h0042;
        bus.req_b[32 +: 16] = 16'h0010;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0110;
        #1;
        n_total++; if (bus.req_ready !== 4'b0010) $display("FAIL bp_grant got=%b want=0010", bus.req_ready); else n_pass++;
        sb.push_back('{id: 2'd1, y: 32'h1234 * 32'h00FF});
        tick();
        tick();
        e = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            n_total++; if (bus.resp_valid !== 1'b1) $display("FAIL bp_resp_valid got=%b want=1 cyc=%0d", bus.resp_valid, k); else n_pass++;
            n_total++; if (bus.resp_y !== e.y)      $display("FAIL bp_resp_y got=%h want=%h cyc=%0d", bus.resp_y, e.y, k); else n_pass++;
            n_total++; if (bus.resp_id !== e.id)    $display("FAIL bp_resp_id got=%0d want=%0d cyc=%0d", bus.resp_id, e.id, k); else n_pass++;
            n_total++; if (bus.req_ready !== 4'b0)  $display("FAIL bp_req_ready got=%b want=0 cyc=%0d", bus.req_ready, k); else n_pass++;
            n_total++; if (bus.mul_en !== 1'b0)     $display("FAIL bp_mul_en got=%b want=0 cyc=%0d", bus.mul_en, k); else n_pass++;
            tick();
        end
        bus.resp_ready = 1'b1;
        tick();
        n_total++; if (bus.resp_valid !== 1'b0)   $display("FAIL bp_release_valid got=%b want=0", bus.resp_valid); else n_pass++;
        n_total++; if (bus.req_ready !== 4'b0100) $display("FAIL bp_idle_grant got=%b want=0100", bus.req_ready); else n_pass++;
        bus.req_valid = '0;
        #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        apply_reset();
        bus.req_a[0 +: 16]  = 16'd77;
        bus.req_b[0 +: 16]  = 16'd99;
        bus.req_a[32 +: 16] = 16'd5;
        bus.req_b[32 +: 16] = 16'd6;
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'b0100;
        #1;
        tick();
        bus.req_valid = '0;
        n_total++; if (bus.mul_en !== 1'b1) $display("FAIL rm_issue got=%b want=1", bus.mul_en); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (bus.mul_en !== 1'b0)     $display("FAIL rm_mul_en got=%b want=0", bus.mul_en); else n_pass++;
        n_total++; if (bus.busy !== 1'b0)       $display("FAIL rm_busy got=%b want=0", bus.busy); else n_pass++;
        n_total++; if (bus.mul_a !== 16'd0)     $display("FAIL rm_mul_a got=%h want=0", bus.mul_a); else n_pass++;
        n_total++; if (bus.resp_y !== 32'd0)    $display("FAIL rm_resp_y got=%h want=0", bus.resp_y); else n_pass++;
        n_total++; if (bus.resp_id !== 2'd0)    $display("FAIL rm_resp_id got=%0d want=0", bus.resp_id); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            n_total++; if (bus.resp_valid !== 1'b0) $display("FAIL rm_no_resp got=%b want=0 cyc=%0d", bus.resp_valid, k); else n_pass++;
            tick();
        end
        bus.req_valid = 4'b1101;
        #1;
        n_total++; if (bus.req_ready !== 4'b0001) $display("FAIL rm_ptr_grant got=%b want=0001", bus.req_ready); else n_pass++;
        sb.push_back('{id: 2'd0, y: 32'd77 * 32'd99});
        tick();
        bus.req_valid = '0;
        tick();
        e = sb.pop_front();
        n_total++; if (bus.resp_valid !== 1'b1) $display("FAIL rm_after_valid got=%b want=1", bus.resp_valid); else n_pass++;
        n_total++; if (bus.resp_id !== e.id)    $display("FAIL rm_after_id got=%0d want=%0d", bus.resp_id, e.id); else n_pass++;
        n_total++; if (bus.resp_y !== e.y)      $display("FAIL rm_after_y got=%h want=%h", bus.resp_y, e.y); else n_pass++;
        tick();
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;
        test_reset();
        test_op(0, 16'd300, 16'd500, 32'h000249F0, "single");
        test_op(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "max");
        test_op(1, 16'd0, 16'd1234, 32'h0, "zero");
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
